// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the CPU's unified memory port (master 0 = CPU, master 1 = loader/debug).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed CPU priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              win_q;  // 0 = cpu, 1 = ext
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;
  logic              any_req;
  logic              grant_ext;
  logic              grant;
  logic              capture;

  assign any_req = cpu_req | ext_req;
  assign grant   = (state_q == StIdle) & any_req;
  assign capture = (state_q == StWait) & (cnt_q == '0);

`ifdef MEM_ARB_RR_EN
  logic last_q;  // 1 = ext won the most recent grant

  // On a tie the master that did not win last time gets the port.
  assign grant_ext = ext_req & (~cpu_req | ~last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= grant_ext;
    end
  end
`else
  assign grant_ext = ext_req & ~cpu_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cnt_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    cpu_done = 1'b0;
    ext_done = 1'b0;
    unique case (state_q)
      StIssue: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      StResp: begin
        cpu_done = ~win_q;
        ext_done = win_q;
      end
      default: begin
      end
    endcase
  end

  // Winner's request is latched once so later input changes cannot disturb the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (grant) begin
        win_q   <= grant_ext;
        we_q    <= grant_ext ? ext_we    : cpu_we;
        addr_q  <= grant_ext ? ext_addr  : cpu_addr;
        wdata_q <= grant_ext ? ext_wdata : cpu_wdata;
      end
      if (state_q == StIssue) begin
        cnt_q <= CntW'(MEM_LAT - 1);
      end else if ((state_q == StWait) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture && !we_q) begin
        if (win_q) begin
          ext_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances under directed and random traffic,
// checked every cycle against a transaction-level timing model (honours MEM_ARB_RR_EN).
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req [2], cpu_we [2], ext_req [2], ext_we [2];
  logic [31:0] cpu_addr [2], cpu_wdata [2], ext_addr [2], ext_wdata [2], mem_rdata [2];
  logic        cpu_done [2], ext_done [2], cpu_stall [2], mem_en [2], mem_we [2];
  logic [31:0] cpu_rdata [2], ext_rdata [2], mem_addr [2], mem_wdata [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_done(cpu_done[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
    .ext_done(ext_done[0]), .ext_rdata(ext_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_done(cpu_done[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
    .ext_done(ext_done[1]), .ext_rdata(ext_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mode  = 2;  // 0 random traffic, 1 both masters always requesting, 2 quiet
  bit nrst  = 1'b1;

  // Next-cycle stimulus, [instance][master], master 0 = cpu, 1 = ext
  logic        nreq [2][2], nwe [2][2];
  logic [31:0] naddr [2][2], nwdata [2][2];

  // Memory environment
  logic [31:0] mem [2][16];
  logic [31:0] pipe_d [2][3];
  bit          pipe_v [2][3];
  logic        prev_en [2], prev_we [2];
  logic [31:0] prev_addr [2], prev_wdata [2];

  // Transaction-level model
  int          free_at [2], issue_c [2], done_c [2], win [2];
  bit          last_ext [2];
  logic        m_we [2];
  logic [31:0] m_addr [2], m_wdata [2], rd_val [2];
  logic [31:0] e_rdata [2][2], e_maddr [2], e_mwdata [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h exp=%h", tag, lat_of(k), cyc, got, exp);
    end
  endtask

  task automatic model_cycle(input int k);
    logic exp_en;
    logic exp_done [2];
    int   w;
    int   c;
    c = cyc;
    if (reset) begin
      free_at[k]    = c + 1;
      issue_c[k]    = -1;
      done_c[k]     = -1;
      e_rdata[k][0] = '0;
      e_rdata[k][1] = '0;
      e_maddr[k]    = '0;
      e_mwdata[k]   = '0;
      last_ext[k]   = 1'b1;
    end
    exp_en = (c == issue_c[k]);
    if (exp_en) begin
      e_maddr[k]  = m_addr[k];
      e_mwdata[k] = m_wdata[k];
      rd_val[k]   = mem[k][m_addr[k][5:2]];
    end
    exp_done[0] = 1'b0;
    exp_done[1] = 1'b0;
    if (c == done_c[k]) begin
      exp_done[win[k]] = 1'b1;
      if (!m_we[k]) e_rdata[k][win[k]] = rd_val[k];
    end
    check("mem_en", k, mem_en[k], exp_en);
    check("mem_we", k, mem_we[k], exp_en & m_we[k]);
    check("mem_addr", k, mem_addr[k], e_maddr[k]);
    check("mem_wdata", k, mem_wdata[k], e_mwdata[k]);
    check("cpu_done", k, cpu_done[k], exp_done[0]);
    check("ext_done", k, ext_done[k], exp_done[1]);
    check("cpu_rdata", k, cpu_rdata[k], e_rdata[k][0]);
    check("ext_rdata", k, ext_rdata[k], e_rdata[k][1]);
    check("cpu_stall", k, cpu_stall[k], cpu_req[k] & ~exp_done[0]);
    prev_en[k]    = mem_en[k];
    prev_we[k]    = mem_we[k];
    prev_addr[k]  = mem_addr[k];
    prev_wdata[k] = mem_wdata[k];
    if (!reset && c >= free_at[k] && (cpu_req[k] || ext_req[k])) begin
      if (cpu_req[k] && ext_req[k]) w = (RoundRobin && !last_ext[k]) ? 1 : 0;
      else w = ext_req[k] ? 1 : 0;
      win[k]      = w;
      last_ext[k] = (w == 1);
      m_we[k]     = w ? ext_we[k] : cpu_we[k];
      m_addr[k]   = w ? ext_addr[k] : cpu_addr[k];
      m_wdata[k]  = w ? ext_wdata[k] : cpu_wdata[k];
      issue_c[k]  = c + 1;
      done_c[k]   = c + lat_of(k) + 2;
      free_at[k]  = c + lat_of(k) + 3;
    end
  endtask

  task automatic decide();
    bit fin, busy;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        fin  = (win[k] == m) && (done_c[k] == cyc);
        busy = (win[k] == m) && (done_c[k] > cyc);
        if (nreq[k][m] && !fin) begin
          // Winner may wiggle its inputs; the latched copy must be used.
          if (busy && mode == 0 && $urandom_range(0, 1) == 1) begin
            nwe[k][m]    = 1'($urandom_range(0, 1));
            naddr[k][m]  = $urandom;
            nwdata[k][m] = $urandom;
          end
        end else begin
          nreq[k][m]   = (mode == 1) || (mode == 0 && $urandom_range(0, 2) == 0);
          nwe[k][m]    = 1'($urandom_range(0, 1));
          naddr[k][m]  = $urandom;
          nwdata[k][m] = $urandom;
        end
      end
    end
    nrst = (mode == 0) && ($urandom_range(0, 59) == 0);
    if (nrst) begin
      for (int k = 0; k < 2; k++) begin
        nreq[k][0] = 1'b0;
        nreq[k][1] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    reset = nrst;
    for (int k = 0; k < 2; k++) begin
      for (int s = 2; s > 0; s--) begin
        pipe_d[k][s] = pipe_d[k][s-1];
        pipe_v[k][s] = pipe_v[k][s-1];
      end
      pipe_v[k][0] = prev_en[k] && !prev_we[k];
      pipe_d[k][0] = mem[k][prev_addr[k][5:2]];
      if (prev_en[k] && prev_we[k]) mem[k][prev_addr[k][5:2]] = prev_wdata[k];
      mem_rdata[k] = pipe_v[k][lat_of(k)-1] ? pipe_d[k][lat_of(k)-1] : $urandom;
      cpu_req[k]   = nreq[k][0];
      cpu_we[k]    = nwe[k][0];
      cpu_addr[k]  = naddr[k][0];
      cpu_wdata[k] = nwdata[k][0];
      ext_req[k]   = nreq[k][1];
      ext_we[k]    = nwe[k][1];
      ext_addr[k]  = naddr[k][1];
      ext_wdata[k] = nwdata[k][1];
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k);
    decide();
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    for (int k = 0; k < 2; k++) begin
      nreq[k][m]   = 1'b1;
      nwe[k][m]    = we;
      naddr[k][m]  = addr;
      nwdata[k][m] = wdata;
    end
  endtask

  task automatic pulse_reset();
    nrst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nreq[k][0] = 1'b0;
      nreq[k][1] = 1'b0;
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mem[k][i] = $urandom;
      mem[k][4] = 32'hDEAD_BEEF;
      for (int s = 0; s < 3; s++) begin
        pipe_d[k][s] = '0;
        pipe_v[k][s] = 1'b0;
      end
      prev_en[k] = 1'b0; prev_we[k] = 1'b0; prev_addr[k] = '0; prev_wdata[k] = '0;
      free_at[k] = 0; issue_c[k] = -1; done_c[k] = -1; win[k] = 0; last_ext[k] = 1'b1;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0; rd_val[k] = '0;
      e_rdata[k][0] = '0; e_rdata[k][1] = '0; e_maddr[k] = '0; e_mwdata[k] = '0;
      mem_rdata[k] = '0;
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      ext_req[k] = 1'b0; ext_we[k] = 1'b0; ext_addr[k] = '0; ext_wdata[k] = '0;
      for (int m = 0; m < 2; m++) begin
        nreq[k][m] = 1'b0; nwe[k][m] = 1'b0; naddr[k][m] = '0; nwdata[k][m] = '0;
      end
    end
    step();
    repeat (3) step();
    pulse_reset();
    repeat (2) step();
    // cpu read of 0x10 returning 0xDEADBEEF
    set_req(0, 1'b0, 32'h10, 32'h0);
    repeat (8) step();
    // ext write of 0x12345678 to 0x40, then cpu reads it back
    set_req(1, 1'b1, 32'h40, 32'h1234_5678);
    repeat (8) step();
    set_req(0, 1'b0, 32'h40, 32'h0);
    repeat (8) step();
    // both masters requesting continuously
    mode = 1;
    repeat (28) step();
    mode = 2;
    repeat (20) step();
    // reset while both instances sit in WAIT, then a clean read
    set_req(0, 1'b0, 32'h10, 32'h0);
    step();
    step();
    pulse_reset();
    set_req(0, 1'b0, 32'h10, 32'h0);
    repeat (8) step();
    // random traffic with occasional resets
    mode = 0;
    repeat (3000) step();
    mode = 2;
    repeat (20) step();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
